// File: rtl/hazard_interlock_pkg.sv
// Shared constants for the register-dependency scoreboard.
// Also holds instruction-word field positions used by decode.
package hazard_interlock_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int NUM_REGS = 32;
    localparam int REG_W = 5;

    // Field positions of rs/rt/rd in the instruction word
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int RD_LSB = 11;

    // Bits needed to hold 0..max_inflight
    function automatic int cnt_width(input int max_inflight);
        return $clog2(max_inflight + 1);
    endfunction

endpackage

// File: rtl/hazard_interlock_reg_pending_counter.sv
// Pending-write counter for one architectural register.
// Retirement of an empty counter is held at 0 and flagged.
module reg_pending_counter #(
    parameter int CW = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_inc,
    input  logic          i_ret,
    output logic [CW-1:0] o_count,
    output logic [CW-1:0] o_count_nxt,
    output logic          o_underflow
);

    logic [CW-1:0] r_cnt;
    logic          w_dec;
    logic [CW-1:0] w_nxt;

    // Next count: a retire only decrements a non-empty counter
    always_comb begin
        w_dec = i_ret & (r_cnt != '0);
        w_nxt = r_cnt + CW'(i_inc) - CW'(w_dec);
    end

    // Count register
    always_ff @(posedge clock) begin
        if (reset) r_cnt <= '0;
        else       r_cnt <= w_nxt;
    end

    assign o_count     = r_cnt;
    assign o_count_nxt = w_nxt;
    assign o_underflow = i_ret & (r_cnt == '0);

endmodule

// File: rtl/hazard_interlock.sv
// Register-dependency scoreboard beside decode.
// Stalls on RAW hazards and on saturated per-register write counts.
module hazard_interlock
    import hazard_interlock_pkg::*;
#(
    parameter int MAX_INFLIGHT = 3,
    parameter int BYPASS_WB    = 1,
    parameter int TIMEOUT      = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dec_valid,
    input  logic [4:0] dec_rs,
    input  logic [4:0] dec_rt,
    input  logic       dec_uses_rs,
    input  logic       dec_uses_rt,
    input  logic [4:0] dec_rd,
    input  logic       dec_writes_rd,
    input  logic [4:0] wb_rd,
    input  logic       wb_we,
    output logic       stall,
    output logic       issue,
    output logic       underflow_err,
    output logic       deadlock_err,
    output logic       pending_any
);

    localparam int CW = cnt_width(MAX_INFLIGHT);

    logic [CW-1:0] w_cnt [NUM_REGS];
    logic [CW-1:0] w_nxt [NUM_REGS];
    logic          w_uf  [NUM_REGS];

    logic r_underflow;
    logic r_deadlock;
    logic r_pending;
    logic [7:0] r_run;

    logic w_raw_rs;
    logic w_raw_rt;
    logic w_waw_full;
    logic w_stall;
    logic w_any_nxt;
    logic w_any_uf;

    assign w_cnt[0] = '0;
    assign w_nxt[0] = '0;
    assign w_uf[0]  = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        logic w_inc;
        logic w_ret;
        assign w_inc = issue & dec_writes_rd & (dec_rd == 5'(r));
        assign w_ret = wb_we & (wb_rd == 5'(r));
        reg_pending_counter #(.CW(CW)) u_cnt (
            .clock       (clock),
            .reset       (reset),
            .i_inc       (w_inc),
            .i_ret       (w_ret),
            .o_count     (w_cnt[r]),
            .o_count_nxt (w_nxt[r]),
            .o_underflow (w_uf[r])
        );
    end

    // Hazard compare; a same-cycle retirement bypasses one pending write
    always_comb begin
        logic [CW-1:0] w_c_rs;
        logic [CW-1:0] w_c_rt;
        logic          w_b_rs;
        logic          w_b_rt;
        w_c_rs = w_cnt[dec_rs];
        w_c_rt = w_cnt[dec_rt];
        w_b_rs = (BYPASS_WB != 0) & wb_we & (wb_rd == dec_rs);
        w_b_rt = (BYPASS_WB != 0) & wb_we & (wb_rd == dec_rt);
        w_raw_rs = dec_uses_rs & (dec_rs != REG_ZERO) & (w_c_rs != '0)
                 & !(w_b_rs & (w_c_rs == CW'(1)));
        w_raw_rt = dec_uses_rt & (dec_rt != REG_ZERO) & (w_c_rt != '0)
                 & !(w_b_rt & (w_c_rt == CW'(1)));
        w_waw_full = dec_writes_rd & (dec_rd != REG_ZERO)
                   & (w_cnt[dec_rd] == CW'(MAX_INFLIGHT))
                   & !(wb_we & (wb_rd == dec_rd));
        w_stall = dec_valid & (w_raw_rs | w_raw_rt | w_waw_full);
    end

    // Reduce next-state counts and underflow strobes
    always_comb begin
        w_any_nxt = 1'b0;
        w_any_uf  = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            w_any_nxt = w_any_nxt | (w_nxt[r] != '0);
            w_any_uf  = w_any_uf | w_uf[r];
        end
    end

    // Stall-run timer, sticky error flags and pending summary
    always_ff @(posedge clock) begin
        if (reset) begin
            r_run       <= '0;
            r_underflow <= 1'b0;
            r_deadlock  <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            if (!w_stall)           r_run <= '0;
            else if (r_run != 8'hFF) r_run <= r_run + 8'd1;
            if (w_any_uf) r_underflow <= 1'b1;
            if (w_stall && r_run == 8'(TIMEOUT - 1)) r_deadlock <= 1'b1;
            r_pending <= w_any_nxt;
        end
    end

    assign stall         = w_stall;
    assign issue         = dec_valid & !w_stall;
    assign underflow_err = r_underflow;
    assign deadlock_err  = r_deadlock;
    assign pending_any   = r_pending;

endmodule

// File: tb/tb_hazard_interlock.sv
// Self-checking bench for hazard_interlock.
// Directed scenarios, then random traffic against a count-based model.
module tb_hazard_interlock;

    localparam int MAXI = 3;
    localparam int TMO  = 64;

    logic       clock = 1'b0;
    logic       reset;
    logic       dec_valid;
    logic [4:0] dec_rs;
    logic [4:0] dec_rt;
    logic       dec_uses_rs;
    logic       dec_uses_rt;
    logic [4:0] dec_rd;
    logic       dec_writes_rd;
    logic [4:0] wb_rd;
    logic       wb_we;
    logic       stall;
    logic       issue;
    logic       underflow_err;
    logic       deadlock_err;
    logic       pending_any;

    hazard_interlock #(
        .MAX_INFLIGHT (MAXI),
        .BYPASS_WB    (1),
        .TIMEOUT      (TMO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .dec_valid     (dec_valid),
        .dec_rs        (dec_rs),
        .dec_rt        (dec_rt),
        .dec_uses_rs   (dec_uses_rs),
        .dec_uses_rt   (dec_uses_rt),
        .dec_rd        (dec_rd),
        .dec_writes_rd (dec_writes_rd),
        .wb_rd         (wb_rd),
        .wb_we         (wb_we),
        .stall         (stall),
        .issue         (issue),
        .underflow_err (underflow_err),
        .deadlock_err  (deadlock_err),
        .pending_any   (pending_any)
    );

    always #5 clock = ~clock;

    int m_cnt [32];
    bit m_uf;
    bit m_dl;
    bit m_pend;
    int m_run;
    int n_chk;
    int n_pass;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b", tag, got, exp);
    endtask

    function automatic int eff(input int r);
        if (r == 0) return 0;
        if (wb_we && int'(wb_rd) == r && m_cnt[r] > 0) return m_cnt[r] - 1;
        return m_cnt[r];
    endfunction

    function automatic bit model_stall();
        bit h;
        h = 0;
        if (dec_uses_rs && eff(int'(dec_rs)) != 0) h = 1;
        if (dec_uses_rt && eff(int'(dec_rt)) != 0) h = 1;
        if (dec_writes_rd && dec_rd != 0 && m_cnt[dec_rd] == MAXI
            && !(wb_we && wb_rd == dec_rd)) h = 1;
        return dec_valid && h;
    endfunction

    task automatic model_clear();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_uf = 0;
        m_dl = 0;
        m_pend = 0;
        m_run = 0;
    endtask

    // Check all outputs against the model, then advance one clock
    task automatic step(input string tag);
        bit st;
        bit is;
        #1;
        st = model_stall();
        is = dec_valid && !st;
        chk({tag, ".stall"}, stall, st);
        chk({tag, ".issue"}, issue, is);
        chk({tag, ".pend"}, pending_any, m_pend);
        chk({tag, ".uf"}, underflow_err, m_uf);
        chk({tag, ".dl"}, deadlock_err, m_dl);
        @(posedge clock);
        if (reset) begin
            model_clear();
        end else begin
            if (wb_we && wb_rd != 0) begin
                if (m_cnt[wb_rd] == 0) m_uf = 1;
                else m_cnt[wb_rd]--;
            end
            if (is && dec_writes_rd && dec_rd != 0) m_cnt[dec_rd]++;
            if (st && m_run == TMO - 1) m_dl = 1;
            m_run = st ? (m_run < 255 ? m_run + 1 : 255) : 0;
            m_pend = 0;
            foreach (m_cnt[i]) if (m_cnt[i] != 0) m_pend = 1;
        end
        @(negedge clock);
    endtask

    task automatic drive(input logic v,
                         input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt,
                         input logic [4:0] rd, input logic wrd,
                         input logic [4:0] wrdx, input logic we);
        dec_valid = v;
        dec_rs = rs;
        dec_uses_rs = urs;
        dec_rt = rt;
        dec_uses_rt = urt;
        dec_rd = rd;
        dec_writes_rd = wrd;
        wb_rd = wrdx;
        wb_we = we;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step("rst");
        reset = 1'b0;
    endtask

    initial begin
        int pend_q[$];
        n_chk = 0;
        n_pass = 0;
        model_clear();
        reset = 1'b1;
        idle();
        @(negedge clock);
        step("rst0");
        reset = 1'b0;
        #1;
        chk("rst.stall", stall, 1'b0);
        chk("rst.pend", pending_any, 1'b0);
        @(negedge clock);

        // 1: write r8
        drive(1, 0, 0, 0, 0, 8, 1, 0, 0);
        #1 chk("t1.issue", issue, 1'b1);
        step("t1");
        idle();
        chk("t1.pend", pending_any, 1'b1);

        // 2: read r8 until it retires
        drive(1, 8, 1, 0, 0, 9, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("t2.stall", stall, 1'b1);
            step("t2");
        end
        wb_rd = 8;
        wb_we = 1;
        #1 chk("t2.byp", stall, 1'b0);
        chk("t2.issue", issue, 1'b1);
        step("t2b");
        drive(0, 0, 0, 0, 0, 0, 0, 9, 1);
        step("t2r");
        idle();
        chk("t2.pend0", pending_any, 1'b0);

        // 3: saturate r5
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
            step("t3w");
        end
        #1 chk("t3.full", stall, 1'b1);
        step("t3f");
        wb_rd = 5;
        wb_we = 1;
        #1 chk("t3.byp", stall, 1'b0);
        step("t3b");
        wb_we = 0;
        #1 chk("t3.still", stall, 1'b1);
        step("t3s");
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 5, 1);
            step("t3r");
        end
        idle();
        chk("t3.pend0", pending_any, 1'b0);

        // 4: r0 is never tracked
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 0, 1, 0, 1, 0, 1);
            #1 chk("t4.stall", stall, 1'b0);
            step("t4");
        end
        idle();
        chk("t4.pend", pending_any, 1'b0);
        chk("t4.uf", underflow_err, 1'b0);

        // 5: underflow is sticky
        drive(0, 0, 0, 0, 0, 0, 0, 12, 1);
        step("t5");
        idle();
        for (int i = 0; i < 3; i++) step("t5h");
        chk("t5.uf", underflow_err, 1'b1);
        do_reset();
        chk("t5.clr", underflow_err, 1'b0);

        // 6: held RAW flags deadlock in cycle 64
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
        step("t6w");
        drive(1, 3, 1, 0, 0, 4, 1, 0, 0);
        for (int i = 1; i <= TMO; i++) begin
            if (i == TMO) chk("t6.dl63", deadlock_err, 1'b0);
            step("t6");
        end
        chk("t6.dl", deadlock_err, 1'b1);
        chk("t6.pend", pending_any, 1'b1);
        do_reset();
        idle();
        chk("t6.dl0", deadlock_err, 1'b0);
        chk("t6.pend0", pending_any, 1'b0);

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            pend_q.delete();
            foreach (m_cnt[i]) if (m_cnt[i] != 0) pend_q.push_back(i);
            dec_valid     = ($urandom_range(0, 9) < 7);
            dec_rs        = 5'($urandom_range(0, 7));
            dec_rt        = 5'($urandom_range(0, 7));
            dec_uses_rs   = 1'($urandom);
            dec_uses_rt   = 1'($urandom);
            dec_rd        = 5'($urandom_range(0, 7));
            dec_writes_rd = ($urandom_range(0, 3) != 0);
            wb_we = 0;
            wb_rd = 5'($urandom_range(0, 31));
            if (pend_q.size() > 0 && $urandom_range(0, 9) < 4) begin
                wb_we = 1;
                wb_rd = 5'(pend_q[$urandom_range(0, pend_q.size() - 1)]);
            end else if ($urandom_range(0, 19) == 0) begin
                wb_we = 1;
                wb_rd = 0;
            end
            reset = ($urandom_range(0, 299) == 0);
            step("rnd");
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
